// File: rtl/plot_arbiter_if.sv
// Sprite-drawer side of the framebuffer arbiter: per-requester request,
// final-pixel flag, pixel payload, and the arbiter's grant/done returns.
//
// Handshake: a drawer holds req[k] high with a valid px/py/pc slice; while
// gnt[k] is high, every cycle with req[k]=1 transfers one pixel (req is the
// pixel-valid, gnt is the ready). last[k] marks the final pixel of the burst
// and is only looked at together with req[k]. Dropping req[k] while granted
// abandons the burst. done[k] pulses once, the cycle after the last pixel.
interface plot_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  last;
    logic [23:0] px;
    logic [20:0] py;
    logic [8:0]  pc;
    logic [2:0]  gnt;
    logic [2:0]  done;

    modport master (output req, output last, output px, output py, output pc,
                    input  gnt, input  done);
    modport slave  (input  req, input  last, input  px, input  py, input  pc,
                    output gnt, output done);
endinterface

// File: rtl/plot_arbiter.sv
// Framebuffer write-port arbiter: an internal full-screen clear sweep plus
// three round-robin sprite drawers (0 rocket, 1 asteroid, 2 laser) share the
// single vga_adapter write port. All outputs are registered.
module plot_arbiter #(
    parameter int         XMAX         = 160,
    parameter int         YMAX         = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_req,
    output logic               clear_done,
    plot_arbiter_if.slave      bus,
    output logic [7:0]         oX,
    output logic [6:0]         oY,
    output logic [2:0]         oColor,
    output logic               writeEn,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic [7:0] X_LAST = 8'(XMAX - 1);
    localparam logic [6:0] Y_LAST = 7'(YMAX - 1);
    localparam logic [8:0] X_LIM  = 9'(XMAX);
    localparam logic [7:0] Y_LIM  = 8'(YMAX);

    state_t      r_state, w_state_nxt;
    logic        r_clear_pend;
    logic [1:0]  r_rr,  w_rr_nxt;
    logic [7:0]  r_cx,  w_cx_nxt;
    logic [6:0]  r_cy,  w_cy_nxt;
    logic [2:0]  r_gnt, w_gnt_nxt;
    logic [2:0]  r_done, w_done_nxt;
    logic        r_clear_done, w_clear_done_nxt;
    logic        r_we,  w_we_nxt;
    logic [7:0]  r_ox,  w_ox_nxt;
    logic [6:0]  r_oy,  w_oy_nxt;
    logic [2:0]  r_oc,  w_oc_nxt;

    logic        w_any_req;
    logic [1:0]  w_win;
    logic [7:0]  w_sel_x;
    logic [6:0]  w_sel_y;
    logic [2:0]  w_sel_c;
    logic        w_sel_last;
    logic        w_accept;
    logic        w_in_range;
    logic        w_sweep_end;
    logic        w_enter_clear;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        w_any_req = |bus.req;
        w_win     = 2'd0;
        case (r_rr)
            2'd0: begin
                if      (bus.req[1]) w_win = 2'd1;
                else if (bus.req[2]) w_win = 2'd2;
                else                 w_win = 2'd0;
            end
            2'd1: begin
                if      (bus.req[2]) w_win = 2'd2;
                else if (bus.req[0]) w_win = 2'd0;
                else                 w_win = 2'd1;
            end
            default: begin
                if      (bus.req[0]) w_win = 2'd0;
                else if (bus.req[1]) w_win = 2'd1;
                else                 w_win = 2'd2;
            end
        endcase
    end

    // Pick the granted drawer's pixel slice; r_rr holds the current winner.
    always_comb begin
        case (r_rr)
            2'd0: begin
                w_sel_x = bus.px[7:0];   w_sel_y = bus.py[6:0];
                w_sel_c = bus.pc[2:0];   w_sel_last = bus.last[0];
            end
            2'd1: begin
                w_sel_x = bus.px[15:8];  w_sel_y = bus.py[13:7];
                w_sel_c = bus.pc[5:3];   w_sel_last = bus.last[1];
            end
            default: begin
                w_sel_x = bus.px[23:16]; w_sel_y = bus.py[20:14];
                w_sel_c = bus.pc[8:6];   w_sel_last = bus.last[2];
            end
        endcase
    end

    // gnt is only non-zero in BURST, so this is "granted drawer is valid".
    assign w_accept      = (r_state == S_BURST) && (|(r_gnt & bus.req));
    assign w_in_range    = ({1'b0, w_sel_x} < X_LIM) && ({1'b0, w_sel_y} < Y_LIM);
    assign w_sweep_end   = (r_cx == X_LAST) && (r_cy == Y_LAST);
    // A clear request in the deciding cycle counts even before it is latched.
    assign w_enter_clear = (r_state == S_IDLE) && (r_clear_pend || clear_req);

    // State register and all registered outputs/counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_clear_pend <= 1'b0;
            r_rr         <= 2'd2;
            r_cx         <= 8'd0;
            r_cy         <= 7'd0;
            r_gnt        <= 3'b000;
            r_done       <= 3'b000;
            r_clear_done <= 1'b0;
            r_we         <= 1'b0;
            r_ox         <= 8'd0;
            r_oy         <= 7'd0;
            r_oc         <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            if (w_enter_clear)  r_clear_pend <= 1'b0;
            else if (clear_req) r_clear_pend <= 1'b1;
            r_rr         <= w_rr_nxt;
            r_cx         <= w_cx_nxt;
            r_cy         <= w_cy_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_clear_done <= w_clear_done_nxt;
            r_we         <= w_we_nxt;
            r_ox         <= w_ox_nxt;
            r_oy         <= w_oy_nxt;
            r_oc         <= w_oc_nxt;
        end
    end

    // Next-state decision: clear beats sprites in IDLE but never pre-empts a burst.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_enter_clear)  w_state_nxt = S_CLEAR;
                else if (w_any_req) w_state_nxt = S_BURST;
            end
            S_CLEAR: begin
                if (w_sweep_end) w_state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (!w_accept || w_sel_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, grant, pointer and sweep counters.
    always_comb begin
        w_rr_nxt         = r_rr;
        w_cx_nxt         = r_cx;
        w_cy_nxt         = r_cy;
        w_gnt_nxt        = r_gnt;
        w_done_nxt       = 3'b000;
        w_clear_done_nxt = 1'b0;
        w_we_nxt         = 1'b0;
        w_ox_nxt         = r_ox;
        w_oy_nxt         = r_oy;
        w_oc_nxt         = r_oc;
        case (r_state)
            S_IDLE: begin
                if (!w_enter_clear && w_any_req) begin
                    w_gnt_nxt = 3'b001 << w_win;
                    w_rr_nxt  = w_win;
                end
            end
            S_CLEAR: begin
                w_gnt_nxt = 3'b000;
                w_we_nxt  = 1'b1;
                w_ox_nxt  = r_cx;
                w_oy_nxt  = r_cy;
                w_oc_nxt  = CLEAR_COLOUR;
                if (w_sweep_end) begin
                    w_clear_done_nxt = 1'b1;
                    w_cx_nxt         = 8'd0;
                    w_cy_nxt         = 7'd0;
                end else if (r_cx == X_LAST) begin
                    w_cx_nxt = 8'd0;
                    w_cy_nxt = r_cy + 7'd1;
                end else begin
                    w_cx_nxt = r_cx + 8'd1;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    // Off-screen pixels are consumed but suppressed at the write strobe.
                    w_ox_nxt = w_sel_x;
                    w_oy_nxt = w_sel_y;
                    w_oc_nxt = w_sel_c;
                    w_we_nxt = w_in_range;
                    if (w_sel_last) begin
                        w_done_nxt = r_gnt;
                        w_gnt_nxt  = 3'b000;
                    end
                end else begin
                    w_gnt_nxt = 3'b000;
                end
            end
            default: w_gnt_nxt = 3'b000;
        endcase
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign clear_done  = r_clear_done;
    assign writeEn     = r_we;
    assign oX          = r_ox;
    assign oY          = r_oy;
    assign oColor      = r_oc;
    assign o_dbg_state = r_state;

endmodule
